// File: rtl/iir_sos_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// iir_sos_sequencer
//
// Sequencer for one Direct Form I biquad:
//    y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2]
// The block time-shares a single external sequential MAC. Each sample takes
// five MAC cycles, one round/saturate cycle, and one or more output cycles.
// The feedback coefficients arrive already negated, so every term is added.
//
// Optional build macro IIR_SOS_SAT_FLAG_EN adds a sticky saturation flag
// output. It is set whenever the output clamp engages and cleared only by rst.
//
// Ports
//    clk, rst           clock, synchronous active-high reset
//    s_valid/s_ready    input sample handshake, s_data = x[n] (Wa, signed)
//    b0,b1,b2,a1,a2     coefficients (Wb, signed, COEF_FRAC fractional bits),
//                       captured only when a sample is accepted
//    mac_en, mac_ld     MAC enable; load (vs accumulate) on the first product
//    mac_a, mac_b       MAC operands (sample/state, coefficient)
//    mac_c              MAC accumulator (48-bit signed, registered in MAC)
//    m_valid/m_ready    output handshake, m_data = y[n] (Wa, signed)
//    sat_flag           sticky clamp indicator (only with IIR_SOS_SAT_FLAG_EN)
// ---------------------------------------------------------------------------
module iir_sos_sequencer #(
   parameter int Wa        = 18,
   parameter int Wb        = 25,
   parameter int COEF_FRAC = 23
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [Wa-1:0] s_data,
   input  logic [Wb-1:0] b0,
   input  logic [Wb-1:0] b1,
   input  logic [Wb-1:0] b2,
   input  logic [Wb-1:0] a1,
   input  logic [Wb-1:0] a2,
   output logic          mac_en,
   output logic          mac_ld,
   output logic [Wa-1:0] mac_a,
   output logic [Wb-1:0] mac_b,
   input  logic [47:0]   mac_c,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [Wa-1:0] m_data
`ifdef IIR_SOS_SAT_FLAG_EN
   ,
   output logic          sat_flag
`endif
);

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   typedef struct packed {
      logic [Wb-1:0] b0;
      logic [Wb-1:0] b1;
      logic [Wb-1:0] b2;
      logic [Wb-1:0] a1;
      logic [Wb-1:0] a2;
   } coef_t;

   localparam logic [2:0] LAST_OP = 3'd4;

   // Rounding/saturation is done one bit wider than the accumulator so the
   // half-LSB add cannot wrap for accumulators near +2^47.
   localparam logic signed [48:0] RND_HALF = 49'sd1 <<< (COEF_FRAC - 1);
   localparam logic signed [48:0] Y_MAX    = (49'sd1 <<< (Wa - 1)) - 49'sd1;
   localparam logic signed [48:0] Y_MIN    = -(49'sd1 <<< (Wa - 1));

   state_t        state, state_nxt;
   logic [2:0]    op;
   coef_t         coef;
   logic [Wa-1:0] x0, x1, x2, y1, y2;

   logic signed [48:0] acc_ext, rnd_sum, rnd_shr;
   logic               sat_hi, sat_lo;
   logic [Wa-1:0]      y_sat;

   // ------------------------------------------------------------------
   // Round half-up, arithmetic shift back to integer, clamp to Wa bits.
   // mac_c holds the full five-term sum during ROUND.
   // ------------------------------------------------------------------
   always_comb begin
      acc_ext = {mac_c[47], mac_c};
      rnd_sum = acc_ext + RND_HALF;
      rnd_shr = rnd_sum >>> COEF_FRAC;
      sat_hi  = rnd_shr > Y_MAX;
      sat_lo  = rnd_shr < Y_MIN;
      if (sat_hi)
         y_sat = Y_MAX[Wa-1:0];
      else if (sat_lo)
         y_sat = Y_MIN[Wa-1:0];
      else
         y_sat = rnd_shr[Wa-1:0];
   end

   // ------------------------------------------------------------------
   // State register and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op     <= '0;
         coef   <= '0;
         x0     <= '0;
         x1     <= '0;
         x2     <= '0;
         y1     <= '0;
         y2     <= '0;
         m_data <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (s_valid) begin
                  x0   <= s_data;
                  coef <= '{b0: b0, b1: b1, b2: b2, a1: a1, a2: a2};
                  op   <= '0;
               end
            end
            MAC: op <= op + 3'd1;
            ROUND: begin
               m_data <= y_sat;
               x2     <= x1;
               x1     <= x0;
               y2     <= y1;
               y1     <= y_sat;
            end
            default: ;
         endcase
      end
   end

`ifdef IIR_SOS_SAT_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst)
         sat_flag <= 1'b0;
      else if (state == ROUND && (sat_hi || sat_lo))
         sat_flag <= 1'b1;
   end
`endif

   // ------------------------------------------------------------------
   // Next state and outputs. Outputs decode the registered state, so a
   // reset in any state forces mac_en/m_valid low on the following cycle.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      mac_en    = 1'b0;
      mac_ld    = 1'b0;
      mac_a     = '0;
      mac_b     = '0;
      m_valid   = 1'b0;
      case (state)
         IDLE: begin
            // Held low while rst is asserted so nothing looks accepted.
            s_ready = !rst;
            if (s_valid)
               state_nxt = MAC;
         end
         MAC: begin
            mac_en = 1'b1;
            mac_ld = (op == 3'd0);
            case (op)
               3'd0:    begin mac_a = x0; mac_b = coef.b0; end
               3'd1:    begin mac_a = x1; mac_b = coef.b1; end
               3'd2:    begin mac_a = x2; mac_b = coef.b2; end
               3'd3:    begin mac_a = y1; mac_b = coef.a1; end
               3'd4:    begin mac_a = y2; mac_b = coef.a2; end
               default: begin mac_a = '0; mac_b = '0;      end
            endcase
            if (op == LAST_OP)
               state_nxt = ROUND;
         end
         ROUND: state_nxt = OUT;
         OUT: begin
            m_valid = 1'b1;
            if (m_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_iir_sos_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for iir_sos_sequencer: directed samples push hand-computed
// outputs into a queue, a monitor pops and compares on every output handshake.
// A behavioural MAC (load/accumulate, no reset) stands in for the shared MAC.
module tb_iir_sos_sequencer;
   localparam int Wa = 18;
   localparam int Wb = 25;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [Wa-1:0] s_data = '0;
   logic [Wb-1:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
   logic          mac_en, mac_ld;
   logic [Wa-1:0] mac_a;
   logic [Wb-1:0] mac_b;
   logic [47:0]   mac_c;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [Wa-1:0] m_data;
`ifdef IIR_SOS_SAT_FLAG_EN
   logic          sat_flag;
`endif

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   iir_sos_sequencer #(.Wa(Wa), .Wb(Wb), .COEF_FRAC(23)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
      .mac_en(mac_en), .mac_ld(mac_ld), .mac_a(mac_a), .mac_b(mac_b),
      .mac_c(mac_c),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef IIR_SOS_SAT_FLAG_EN
      , .sat_flag(sat_flag)
`endif
   );

   // External MAC: registered accumulator, deliberately not reset.
   logic signed [47:0] ea, eb, acc;
   assign ea    = $signed(mac_a);
   assign eb    = $signed(mac_b);
   assign mac_c = acc;
   always @(posedge clk)
      if (mac_en) acc <= mac_ld ? ea * eb : acc + ea * eb;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (m_valid && m_ready && !rst) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL m_data: got unexpected output %0d expected none",
                        $signed(m_data));
            end else begin
               e = exp_q.pop_front();
               check("m_data", $signed(m_data), e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic set_coef(input int c0, input int c1, input int c2,
                           input int c3, input int c4);
      b0 = c0[Wb-1:0]; b1 = c1[Wb-1:0]; b2 = c2[Wb-1:0];
      a1 = c3[Wb-1:0]; a2 = c4[Wb-1:0];
   endtask

   // Wait for s_ready, present one sample, return 1ns after the accept edge.
   task automatic send(input int d, input bit push, input int e);
      int t = 0;
      @(negedge clk);
      while (!s_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL s_ready_wait: got 0 expected 1");
      end
      s_valid = 1'b1;
      s_data  = d[Wa-1:0];
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      // ---- reset state ----
      @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_mac_ld", mac_ld, 0);
      check("rst_mac_a", mac_a, 0);
      check("rst_mac_b", mac_b, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_s_ready", s_ready, 1);

      // ---- passthrough with latency and MAC strobe checks ----
      set_coef(1 << 23, 0, 0, 0, 0);
      send(1000, 1, 1000);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k <= 5) begin
            check("pt_mac_en", mac_en, 1);
            check("pt_mac_ld", mac_ld, (k == 1) ? 1 : 0);
            check("pt_s_ready", s_ready, 0);
         end else begin
            check("pt_mac_en_off", mac_en, 0);
         end
         if (k == 1) begin
            check("pt_mac_a", $signed(mac_a), 1000);
            check("pt_mac_b", mac_b, 1 << 23);
         end
         if (k == 6) check("pt_round_m_valid", m_valid, 0);
         if (k == 7) check("pt_out_m_valid", m_valid, 1);
      end
      drain();

      // ---- pure delay: b1 only ----
      do_reset();
      set_coef(0, 1 << 23, 0, 0, 0);
      send(5, 1, 0);
      send(7, 1, 5);
      send(9, 1, 7);
      drain();

      // ---- feedback: y = x + 0.5*y[n-1] ----
      do_reset();
      set_coef(1 << 23, 0, 0, 1 << 22, 0);
      send(1024, 1, 1024);
      send(0, 1, 512);
      send(0, 1, 256);
      send(0, 1, 128);
      send(0, 1, 64);
      drain();

      // ---- rounding: half-up on 0.5 gain ----
      do_reset();
      set_coef(1 << 22, 0, 0, 0, 0);
      send(3, 1, 2);
      send(-3, 1, -1);
      drain();

      // ---- saturation: gain just under 2 ----
      do_reset();
      set_coef((1 << 24) - 1, 0, 0, 0, 0);
`ifdef IIR_SOS_SAT_FLAG_EN
      check("sat_flag_clear", sat_flag, 0);
`endif
      send(131071, 1, 131071);
      drain();
`ifdef IIR_SOS_SAT_FLAG_EN
      check("sat_flag_set", sat_flag, 1);
`endif
      send(-131072, 1, -131072);
      drain();

      // ---- backpressure ----
      do_reset();
      set_coef(1 << 23, 0, 0, 0, 0);
      m_ready = 1'b0;
      send(321, 1, 321);
      begin
         int t = 0;
         @(negedge clk);
         while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      for (int k = 0; k < 10; k++) begin
         if (k != 0) @(negedge clk);
         check("bp_m_valid", m_valid, 1);
         check("bp_m_data", $signed(m_data), 321);
         check("bp_s_ready", s_ready, 0);
         check("bp_mac_en", mac_en, 0);
         s_valid = 1'b1;
         s_data  = 18'd999;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);               // monitor consumes 321 here
      @(negedge clk);
      check("bp_release_m_valid", m_valid, 0);
      check("bp_release_s_ready", s_ready, 1);
      repeat (3) begin
         @(negedge clk);
         check("bp_no_extra_mac", mac_en, 0);
      end

      // ---- reset during op 2 clears the delay line ----
      set_coef(0, 1 << 23, 0, 0, 0);
      send(77, 1, 321);             // x[n-1] from the backpressure sample
      drain();
      send(88, 0, 0);               // now in op 0
      @(posedge clk);               // op 1
      @(posedge clk);               // op 2
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_s_ready", s_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_mac_en", mac_en, 0);
      check("midrst_m_valid", m_valid, 0);
      check("midrst_s_ready_after", s_ready, 1);
      set_coef(0, 1 << 23, 0, 0, 0);
      send(50, 1, 0);
      drain();
      repeat (5) @(negedge clk);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
